// File: rtl/stopwatch_controller_n.sv
// Stopwatch mode controller for N time fields.
// Runs entirely on clk. It produces a one-cycle count enable (tick),
// per-field increment enables and a per-field blink mask. The mode is
// selected by a RUN/PAUSE/ADJUST state machine.
module stopwatch_controller_n #(
    parameter int TICK_DIV   = 100000000,
    parameter int ADJ_DIV    = 50000000,
    parameter int BLINK_DIV  = 25000000,
    parameter int NUM_FIELDS = 2,
    parameter int SEL_W      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  adj,
    input  logic [SEL_W-1:0]      sel,
    output logic                  tick,
    output logic [NUM_FIELDS-1:0] inc_en,
    output logic [NUM_FIELDS-1:0] blink_mask,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSE  = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    // One tick counter serves both modes, so it is sized for the larger divider.
    localparam int MAX_DIV = (TICK_DIV > ADJ_DIV) ? TICK_DIV : ADJ_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   ADJ_LAST   = CNT_W'(ADJ_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    state_t                  state_q;
    state_t                  next_state;
    logic                    pause_q;
    logic                    pause_rise;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        div_last;
    logic                    counting;
    logic [BLINK_W-1:0]      blink_cnt_q;
    logic                    blink_phase;
    logic [NUM_FIELDS-1:0]   sel_onehot;

    assign pause_rise = pause & ~pause_q;
    assign state      = state_q;

    // State register and pause edge-detect history.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        //       samples pre-edge values, so the result does not depend on process order.
        if (reset) begin
            state_q <= ST_RUN;
            pause_q <= 1'b0;
        end else begin
            state_q <= next_state;
            pause_q <= pause;
        end
    end

    // Next-state logic. A pause edge outranks the adj switch.
    always_comb begin
        // NOTE: assign a default first so that no path leaves next_state unassigned.
        //       An unassigned path would infer a latch.
        next_state = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (pause_rise)
                    next_state = ST_PAUSE;
                else if (adj)
                    next_state = ST_ADJUST;
                else
                    next_state = ST_RUN;
            end
            ST_ADJUST: begin
                if (pause_rise)
                    next_state = ST_PAUSE;
                else if (!adj)
                    next_state = ST_RUN;
                else
                    next_state = ST_ADJUST;
            end
            ST_PAUSE: begin
                if (pause_rise)
                    next_state = adj ? ST_ADJUST : ST_RUN;
                else
                    next_state = ST_PAUSE;
            end
            default: next_state = ST_RUN;
        endcase
    end

    // Mode outputs: increment enables and blink mask, decoded from the registered state.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (int'(sel) == i)
                sel_onehot[i] = 1'b1;
        end

        case (state_q)
            ST_RUN:    inc_en = '1;
            ST_ADJUST: inc_en = sel_onehot;
            default:   inc_en = '0;
        endcase

        blink_mask = (state_q == ST_ADJUST && blink_phase) ? sel_onehot : '0;
    end

    // The counter only advances while staying in a counting mode.
    // On a state change it restarts from zero, so the first tick in the
    // new mode lands a full divider period after the state update.
    assign div_last = (state_q == ST_ADJUST) ? ADJ_LAST : TICK_LAST;
    assign counting = (state_q == ST_RUN || state_q == ST_ADJUST) && (next_state == state_q);

    // Tick divider. tick is registered and is high for one cycle per wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (!counting) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == div_last) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

    // Free-running blink phase generator. Mode changes do not disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_stopwatch_controller_n.sv
// Directed bench for stopwatch_controller_n with small dividers.
// The parameters are TICK_DIV=10, ADJ_DIV=5, BLINK_DIV=3, NUM_FIELDS=3 and SEL_W=2.
module tb_stopwatch_controller_n;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic       adj   = 1'b0;
    logic [1:0] sel   = 2'd0;
    logic       tick;
    logic [2:0] inc_en;
    logic [2:0] blink_mask;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       p;
        logic       a;
        logic [1:0] s;
        logic [1:0] st;
        logic [2:0] inc;
        logic       chk_m;
    } vec_t;

    vec_t vecs[20];

    int         n;
    int         tick_cnt;
    int         first_tick;
    int         last_tick;
    int         bad;
    int         k;
    logic [2:0] m[14];
    logic [2:0] exp_m;

    stopwatch_controller_n #(
        .TICK_DIV  (10),
        .ADJ_DIV   (5),
        .BLINK_DIV (3),
        .NUM_FIELDS(3),
        .SEL_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pause     (pause),
        .adj       (adj),
        .sel       (sel),
        .tick      (tick),
        .inc_en    (inc_en),
        .blink_mask(blink_mask),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge, then settle just past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Return the number of edges until tick is seen, or -1 if the limit expires.
    task automatic wait_tick(input int limit, output int cnt);
        cnt = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (tick === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        // Row fields: rst, pause, adj, sel, expected state, expected inc_en, mask known to be 0.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 3'b001, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 3'b100, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd2, 3'b000, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 3'b000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 3'b000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 3'b000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 3'b000, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 3'b000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 3'b000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 3'b010, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 3'b111, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1};

        // Reset state.
        cyc();
        cyc();
        check("rst_state", state, 2'd0);
        check("rst_tick", tick, 1'b0);
        check("rst_inc_en", inc_en, 3'b111);
        check("rst_blink", blink_mask, 3'b000);
        reset = 1'b0;

        // RUN for 40 cycles: ticks at edges 10, 20, 30 and 40 after the reset edge.
        tick_cnt   = 0;
        first_tick = -1;
        last_tick  = -1;
        bad        = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (state !== 2'd0 || inc_en !== 3'b111 || blink_mask !== 3'b000)
                bad++;
            if (tick === 1'b1) begin
                if (first_tick < 0)
                    first_tick = i;
                else if (i - last_tick != 10)
                    bad++;
                last_tick = i;
                tick_cnt++;
            end
        end
        check("run_tick_count", tick_cnt, 4);
        check("run_first_tick", first_tick, 10);
        check("run_outputs_and_spacing", bad, 0);

        // Pause pulse: no ticks for 30 cycles. Then resume with a fresh 10-cycle period.
        for (int i = 0; i < 5; i++)
            cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pause_state", state, 2'd1);
        check("pause_inc_en", inc_en, 3'b000);
        check("pause_tick", tick, 1'b0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (tick !== 1'b0 || state !== 2'd1)
                bad++;
        end
        check("pause_hold_no_tick", bad, 0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("resume_state", state, 2'd0);
        wait_tick(20, n);
        check("resume_first_tick", n, 10);

        // ADJUST with sel=1.
        adj = 1'b1;
        sel = 2'd1;
        cyc();
        check("adj_state", state, 2'd2);
        check("adj_inc_en", inc_en, 3'b010);
        wait_tick(12, n);
        check("adj_first_tick", n, 5);
        wait_tick(12, n);
        check("adj_tick_period", n, 5);

        // The blink mask alternates between 010 and 000 in runs of 3 cycles.
        for (int i = 0; i < 14; i++) begin
            cyc();
            m[i] = blink_mask;
        end
        k = -1;
        for (int i = 1; i < 14; i++)
            if (k < 0 && m[i] !== m[i-1])
                k = i;
        check("blink_first_edge_found", (k >= 1 && k <= 5), 1'b1);
        if (k >= 1 && k <= 5) begin
            check("blink_values", {m[k] ^ m[k-1], m[k] | m[k-1]}, {3'b010, 3'b010});
            bad = 0;
            for (int j = 0; j < 9; j++) begin
                exp_m = ((j / 3) % 2 == 0) ? m[k] : m[k-1];
                if (m[k+j] !== exp_m)
                    bad++;
            end
            check("blink_period", bad, 0);
        end

        // Retarget sel out of range mid-period. The tick phase must be unchanged.
        wait_tick(12, n);
        check("adj_resync", (n >= 1 && n <= 5), 1'b1);
        cyc();
        cyc();
        sel = 2'd3;
        cyc();
        check("sel3_inc_en", inc_en, 3'b000);
        check("sel3_blink", blink_mask, 3'b000);
        wait_tick(12, n);
        check("sel3_tick_not_restarted", n, 2);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (blink_mask !== 3'b000 || inc_en !== 3'b000)
                bad++;
        end
        check("sel3_mask_stays_zero", bad, 0);

        // Holding pause high in ADJUST toggles only once. The next pulse returns to ADJUST.
        sel   = 2'd1;
        pause = 1'b1;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (state !== 2'd1)
                bad++;
        end
        check("held_pause_single_toggle", bad, 0);
        pause = 1'b0;
        cyc();
        check("held_pause_release", state, 2'd1);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pause_back_to_adjust", state, 2'd2);
        cyc();

        // Pause has priority over a simultaneous drop of adj.
        pause = 1'b1;
        adj   = 1'b0;
        cyc();
        pause = 1'b0;
        check("pause_priority", state, 2'd1);
        cyc();
        check("adj_drop_ignored_in_pause", state, 2'd1);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pause_to_run", state, 2'd0);

        // Reset on the edge where the ADJUST tick would fire.
        adj = 1'b1;
        cyc();
        check("pre_reset_adjust", state, 2'd2);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (tick !== 1'b0)
                bad++;
        end
        check("pre_reset_no_tick", bad, 0);
        reset = 1'b1;
        cyc();
        check("reset_tick_suppressed", tick, 1'b0);
        check("reset_mid_state", state, 2'd0);
        check("reset_mid_blink", blink_mask, 3'b000);
        reset = 1'b0;
        adj   = 1'b0;
        sel   = 2'd0;
        wait_tick(20, n);
        check("post_reset_first_tick", n, 10);

        // Table-driven transition vectors, one edge per row.
        for (int i = 0; i < 20; i++) begin
            reset = vecs[i].rst;
            pause = vecs[i].p;
            adj   = vecs[i].a;
            sel   = vecs[i].s;
            cyc();
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_inc_en", i), inc_en, vecs[i].inc);
            check($sformatf("vec%0d_tick", i), tick, 1'b0);
            if (vecs[i].chk_m)
                check($sformatf("vec%0d_blink", i), blink_mask, 3'b000);
        end
        reset = 1'b0;
        pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
